// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter and the control unit:
// size and error codes, RAM_OpCode layout and the sequencer states.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_TMO   = 2'b10
  } err_cause_e;

  typedef struct packed {
    logic [1:0] rsvd;
    logic       we;
    logic       sgn;
    size_e      size;
  } ram_op_t;

  typedef enum logic [1:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ACCESS,
    ST_RELEASE
  } state_e;

  function automatic ram_op_t mk_op(logic is_store, logic is_signed, size_e sz);
    ram_op_t op;
    op.rsvd = 2'b00;
    op.we   = is_store;
    op.sgn  = is_signed;
    op.size = sz;
    return op;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_align_chk.sv
// Alignment check for a (size, address) pair; also used by the trap logic.
module mem_align_chk
  import mem_pkg::*;
(
  input  size_e      size,
  input  logic [1:0] addr_lo,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto the single RAM port, runs the
// MFC handshake and reports misalignment and timeout errors.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic              RAM_enable,
  output logic [5:0]        RAM_OpCode,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              MFC
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_e        state, state_n;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_d;
  logic          grant, grant_d, ack_d, align_ok;
  logic          done_ok, done_err;
  err_cause_e    cause_n;
  size_e         sel_size;
  logic [31:0]   sel_addr;
  ram_op_t       sel_op;
  logic          unused_addr_hi;

  // Data wins unless fetch has already been passed over STARVE_MAX times.
  assign grant_d  = d_req && !(if_req && starve_cnt == SW'(STARVE_MAX));
  assign grant    = (state == ST_IDLE) && (d_req || if_req);
  assign sel_size = grant_d ? size_e'(d_size) : SZ_WORD;
  assign sel_addr = grant_d ? d_addr : if_addr;
  assign sel_op   = mk_op(grant_d & d_we, grant_d & d_signed, sel_size);
  assign ack_d    = (state == ST_IDLE) ? grant_d : owner_d;
  assign unused_addr_hi = ^sel_addr[31:ADDR_W];

  assign RAM_enable = (state == ST_ACCESS);

  mem_align_chk u_align (
    .size    (sel_size),
    .addr_lo (sel_addr[1:0]),
    .ok      (align_ok)
  );

  always_comb begin
    state_n  = state;
    done_ok  = 1'b0;
    done_err = 1'b0;
    cause_n  = ERR_NONE;
    unique case (state)
      ST_DRAIN:   if (!MFC) state_n = ST_IDLE;
      ST_IDLE: begin
        if (grant) begin
          if (!align_ok) begin
            done_err = 1'b1;
            cause_n  = ERR_ALIGN;
            state_n  = ST_RELEASE;
          end else begin
            state_n = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (MFC) begin
          done_ok = 1'b1;
          state_n = ST_RELEASE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          done_err = 1'b1;
          cause_n  = ERR_TMO;
          state_n  = ST_RELEASE;
        end
      end
      ST_RELEASE: if (!MFC) state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state      <= ST_DRAIN;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      err_cause  <= '0;
      RAM_OpCode <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      state  <= state_n;
      if_ack <= (done_ok || done_err) && !ack_d;
      d_ack  <= (done_ok || done_err) && ack_d;
      if (done_ok || done_err) begin
        err       <= done_err;
        err_cause <= cause_n;
      end
      if (done_ok) rdata <= ram_rdata;
      tmo_cnt <= (state == ST_ACCESS && state_n == ST_ACCESS) ? tmo_cnt + 1'b1 : '0;
      if (grant) begin
        owner_d    <= grant_d;
        ram_addr   <= sel_addr[ADDR_W-1:0];
        RAM_OpCode <= sel_op;
        ram_wdata  <= grant_d ? d_wdata : '0;
        if (!grant_d) starve_cnt <= '0;
        else if (if_req && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural RAM model.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        RESET, if_req, d_req, d_we, d_signed, MFC;
  logic [31:0] if_addr, d_addr, d_wdata, ram_rdata, rdata, ram_wdata;
  logic [1:0]  d_size, err_cause;
  logic        if_ack, d_ack, err, RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic [8:0]  ram_addr;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.ADDR_W(9), .TIMEOUT(15), .STARVE_MAX(4)) dut (
    .Clk(Clk), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err), .err_cause(err_cause),
    .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .MFC(MFC)
  );

  typedef struct {
    bit          is_d;
    bit          chk_rdata;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
    logic [5:0]  op;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ack_cyc = 0;
  int   en_rise_cyc = 0;
  bit   en_seen = 0;
  int   lat = 1;
  int   ecnt = 0;
  bit   force_mfc = 0;
  logic [31:0] rd_val = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic exp_t mk(bit is_d, bit chk_rd, logic [31:0] rd, logic e,
                              logic [1:0] c, logic [5:0] op);
    exp_t x;
    x.is_d = is_d; x.chk_rdata = chk_rd; x.rdata = rd;
    x.err = e; x.cause = c; x.op = op;
    return x;
  endfunction

  // RAM model: MFC rises lat cycles after RAM_enable (lat=0 means never).
  initial begin
    MFC = 1'b0;
    ram_rdata = '0;
    forever begin
      @(posedge Clk); #1;
      cyc++;
      if (RAM_enable) begin
        if (ecnt == 0) en_rise_cyc = cyc;
        ecnt++;
        en_seen = 1'b1;
        if (lat > 0 && ecnt >= lat) begin
          MFC = 1'b1;
          ram_rdata = rd_val;
        end
      end else begin
        ecnt = 0;
        MFC = 1'b0;
      end
      if (force_mfc) MFC = 1'b1;
    end
  end

  // Monitor: every ack is matched against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk); #2;
      if (!RESET && (if_ack || d_ack)) begin
        ack_cyc = cyc;
        if (if_ack && d_ack) chk("dual_ack", {if_ack, d_ack}, 2'b01);
        if (q.size() == 0) begin
          chk("unexpected_ack", {if_ack, d_ack}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("ack_owner", d_ack, e.is_d);
          if (e.chk_rdata) chk("rdata", rdata, e.rdata);
          chk("err", err, e.err);
          chk("err_cause", err_cause, e.cause);
          chk("opcode", RAM_OpCode, e.op);
        end
      end
    end
  end

  task automatic wait_sig(input bit is_d, input string nm);
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #3;
      if (is_d ? d_ack : if_ack) return;
    end
    chk({nm, "_ack_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #3; end
  endtask

  task automatic set_d(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    RESET = 1'b1; if_req = 0; d_req = 0; if_addr = '0;
    set_d(0, 2'b00, 0, '0, '0);

    // Reset state
    idle(3);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cause", err_cause, 0);
    chk("rst_enable", RAM_enable, 0);
    chk("rst_opcode", RAM_OpCode, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    RESET = 1'b0;
    idle(3);

    // Fetch at 0x40, MFC two cycles after enable
    rd_val = 32'h82102005; lat = 2;
    q.push_back(mk(0, 1, 32'h82102005, 0, 2'b00, 6'b000010));
    c0 = cyc; if_req = 1; if_addr = 32'h40;
    wait_sig(0, "fetch1"); if_req = 0;
    chk("fetch1_latency", ack_cyc - c0, 3);
    chk("fetch1_ram_addr", ram_addr, 9'h040);
    idle(3);

    // Minimum latency: MFC one cycle after enable
    rd_val = 32'h13572468; lat = 1;
    q.push_back(mk(0, 1, 32'h13572468, 0, 2'b00, 6'b000010));
    c0 = cyc; if_req = 1; if_addr = 32'h44;
    wait_sig(0, "fetch_min"); if_req = 0;
    chk("fetch_min_latency", ack_cyc - c0, 2);
    idle(3);

    // Simultaneous data (signed byte load at 0xE1) and fetch: data first
    rd_val = 32'h12345678; lat = 2;
    q.push_back(mk(1, 1, 32'h12345678, 0, 2'b00, 6'b000100));
    q.push_back(mk(0, 1, 32'h12345678, 0, 2'b00, 6'b000010));
    set_d(0, 2'b00, 1, 32'hE1, '0);
    d_req = 1; if_req = 1; if_addr = 32'h48;
    fork
      begin wait_sig(1, "simul_d"); d_req = 0; end
      begin wait_sig(0, "simul_f"); if_req = 0; end
    join
    chk("simul_ram_addr", ram_addr, 9'h048);
    idle(3);

    // Continuous data with fetch pending: four data grants, then fetch
    rd_val = 32'hCAFE0000; lat = 1;
    for (int k = 0; k < 4; k++) q.push_back(mk(1, 1, 32'hCAFE0000, 0, 2'b00, 6'b000101));
    q.push_back(mk(0, 1, 32'hCAFE0000, 0, 2'b00, 6'b000010));
    q.push_back(mk(1, 1, 32'hCAFE0000, 0, 2'b00, 6'b000101));
    set_d(0, 2'b01, 1, 32'h12, '0);
    d_req = 1; if_req = 1; if_addr = 32'h4C;
    fork
      begin
        wait_sig(0, "starve_f"); if_req = 0;
        chk("starve_cnt_cleared", 32'(dut.starve_cnt), 0);
      end
      begin repeat (5) wait_sig(1, "starve_d"); d_req = 0; end
    join
    idle(3);

    // Misaligned halfword store at 0xE3
    en_seen = 0; lat = 1;
    q.push_back(mk(1, 0, '0, 1, 2'b01, 6'b001001));
    set_d(1, 2'b01, 0, 32'hE3, 32'h0000BEEF);
    c0 = cyc; d_req = 1;
    wait_sig(1, "misalign"); d_req = 0;
    chk("misalign_latency", ack_cyc - c0, 1);
    chk("misalign_wdata", ram_wdata, 32'h0000BEEF);
    idle(3);
    chk("misalign_no_enable", en_seen, 0);

    // Illegal size at address 0
    en_seen = 0;
    q.push_back(mk(1, 0, '0, 1, 2'b01, 6'b000011));
    set_d(0, 2'b11, 0, 32'h0, '0);
    d_req = 1;
    wait_sig(1, "illegal"); d_req = 0;
    idle(3);
    chk("illegal_no_enable", en_seen, 0);

    // Timeout: MFC never arrives
    lat = 0;
    q.push_back(mk(1, 0, '0, 1, 2'b10, 6'b000010));
    set_d(0, 2'b10, 0, 32'h20, '0);
    d_req = 1;
    wait_sig(1, "timeout"); d_req = 0;
    chk("timeout_cycles", ack_cyc - en_rise_cyc, 15);
    idle(3);

    // Reset mid-access with MFC rising the same cycle
    lat = 0;
    set_d(0, 2'b10, 0, 32'h30, '0);
    d_req = 1;
    for (int i = 0; i < 20 && !RAM_enable; i++) idle(1);
    chk("rst_mid_enable_seen", RAM_enable, 1);
    idle(1);
    RESET = 1; force_mfc = 1; d_req = 0;
    idle(1);
    chk("rst_mid_enable_drop", RAM_enable, 0);
    chk("rst_mid_no_ack", {if_ack, d_ack}, 2'b00);
    RESET = 0;
    rd_val = 32'h0BADF00D; lat = 1;
    q.push_back(mk(0, 1, 32'h0BADF00D, 0, 2'b00, 6'b000010));
    if_req = 1; if_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("drain_holds", RAM_enable, 0);
    end
    force_mfc = 0;
    wait_sig(0, "post_reset_fetch"); if_req = 0;
    chk("post_reset_ram_addr", ram_addr, 9'h080);
    idle(4);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
